// File: rtl/uart_fib_streamer.sv
// uart_fib_streamer: receives one count byte N over an 8N1 UART line and
// streams the first N terms of 1, 2, 3, 5, 8, ... as 32-bit words on a
// one-cycle strobe, followed by a terminating zero word.
//
// Receiver FSM
//   state    | meaning
//   RX_IDLE  | line idle, watching for a start edge
//   RX_START | waiting half a bit period to confirm the start bit
//   RX_DATA  | sampling 8 data bits, LSB first, one per bit period
//   RX_STOP  | sampling the stop bit; on framing error waits for line high
//
// Generator FSM
//   state    | meaning
//   GEN_IDLE | waiting for a received count byte
//   GEN_RUN  | alternating output cycle / gap cycle until count is exhausted
//   GEN_TERM | emitting the terminating zero word

module uart_fib_streamer #(
   parameter int CLKS_PER_BIT = 5
) (
   input  logic        clk,
   input  logic        xreset,
   input  logic        rs_rx,
   output logic [31:0] send_data,
   output logic        send_enable
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TW   = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LOAD = TW'(HALF - 1);
   localparam logic [TW-1:0] TMR_ONE   = TW'(1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      GEN_IDLE,
      GEN_RUN,
      GEN_TERM
   } gen_state_t;

   logic            rx_meta;
   logic            rx_sync;

   rx_state_t       rx_state, rx_state_nxt;
   logic [TW-1:0]   tmr, tmr_nxt;
   logic [2:0]      bit_cnt, bit_cnt_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic            ferr, ferr_nxt;
   logic            rx_valid;
   logic [7:0]      rx_byte;

   gen_state_t      gen_state, gen_state_nxt;
   logic            phase, phase_nxt;
   logic [7:0]      cnt, cnt_nxt;
   logic [31:0]     term_a, term_a_nxt;
   logic [31:0]     term_b, term_b_nxt;
   logic            send_enable_nxt;
   logic [31:0]     send_data_nxt;

   // Two-flop synchroniser on the asynchronous receive line, idling high.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rs_rx;
         rx_sync <= rx_meta;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         rx_state <= RX_IDLE;
         tmr      <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         ferr     <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         tmr      <= tmr_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shreg    <= shreg_nxt;
         ferr     <= ferr_nxt;
      end
   end

   // Receiver next-state: down-counting bit timer, sample on terminal count.
   always_comb begin
      rx_state_nxt = rx_state;
      tmr_nxt      = tmr;
      bit_cnt_nxt  = bit_cnt;
      shreg_nxt    = shreg;
      ferr_nxt     = ferr;
      rx_valid     = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_state_nxt = RX_START;
               tmr_nxt      = HALF_LOAD;
               bit_cnt_nxt  = '0;
            end
         end
         RX_START: begin
            if (tmr != '0) begin
               tmr_nxt = tmr - TMR_ONE;
            end else if (!rx_sync) begin
               rx_state_nxt = RX_DATA;
               tmr_nxt      = BIT_LOAD;
            end else begin
               rx_state_nxt = RX_IDLE;
            end
         end
         RX_DATA: begin
            if (tmr != '0) begin
               tmr_nxt = tmr - TMR_ONE;
            end else begin
               shreg_nxt = {rx_sync, shreg[7:1]};
               tmr_nxt   = BIT_LOAD;
               if (bit_cnt == 3'd7) begin
                  rx_state_nxt = RX_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         RX_STOP: begin
            // After a framing error the byte is discarded and we only
            // wait for the line to go idle before hunting for a new start.
            if (ferr) begin
               if (rx_sync) begin
                  ferr_nxt     = 1'b0;
                  rx_state_nxt = RX_IDLE;
               end
            end else if (tmr != '0) begin
               tmr_nxt = tmr - TMR_ONE;
            end else if (rx_sync) begin
               rx_valid     = 1'b1;
               rx_state_nxt = RX_IDLE;
            end else begin
               ferr_nxt = 1'b1;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   assign rx_byte = shreg;

   // Generator state, term registers and registered strobe outputs.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         gen_state   <= GEN_IDLE;
         phase       <= 1'b0;
         cnt         <= '0;
         term_a      <= '0;
         term_b      <= '0;
         send_enable <= 1'b0;
         send_data   <= '0;
      end else begin
         gen_state   <= gen_state_nxt;
         phase       <= phase_nxt;
         cnt         <= cnt_nxt;
         term_a      <= term_a_nxt;
         term_b      <= term_b_nxt;
         send_enable <= send_enable_nxt;
         send_data   <= send_data_nxt;
      end
   end

   // Generator next-state: bytes arriving outside IDLE are ignored.
   always_comb begin
      gen_state_nxt   = gen_state;
      phase_nxt       = phase;
      cnt_nxt         = cnt;
      term_a_nxt      = term_a;
      term_b_nxt      = term_b;
      send_enable_nxt = 1'b0;
      send_data_nxt   = send_data;
      case (gen_state)
         GEN_IDLE: begin
            if (rx_valid) begin
               cnt_nxt       = rx_byte;
               term_a_nxt    = 32'd1;
               term_b_nxt    = 32'd2;
               phase_nxt     = 1'b0;
               gen_state_nxt = (rx_byte != 8'd0) ? GEN_RUN : GEN_TERM;
            end
         end
         GEN_RUN: begin
            if (!phase) begin
               send_enable_nxt = 1'b1;
               send_data_nxt   = term_a;
               term_a_nxt      = term_b;
               term_b_nxt      = term_a + term_b;
               cnt_nxt         = cnt - 8'd1;
               phase_nxt       = 1'b1;
            end else begin
               phase_nxt = 1'b0;
               if (cnt == 8'd0) begin
                  gen_state_nxt = GEN_TERM;
               end
            end
         end
         GEN_TERM: begin
            send_enable_nxt = 1'b1;
            send_data_nxt   = 32'd0;
            gen_state_nxt   = GEN_IDLE;
         end
         default: gen_state_nxt = GEN_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_fib_streamer.sv
// Directed bench for uart_fib_streamer: serial count bytes in, expected
// word stream queued per byte and checked strobe by strobe.
`timescale 1ns/1ps

module tb_uart_fib_streamer;

   localparam int CPB = 5;

   logic        clk;
   logic        xreset;
   logic        rs_rx;
   logic [31:0] send_data;
   logic        send_enable;

   int          total = 0;
   int          bad = 0;
   int          strobes = 0;
   logic [31:0] q[$];
   logic [31:0] mon_exp;
   logic        prev_en = 1'b0;

   uart_fib_streamer #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .xreset      (xreset),
      .rs_rx       (rs_rx),
      .send_data   (send_data),
      .send_enable (send_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every strobe pops one expected word.
   always @(negedge clk) begin
      if (xreset === 1'b1 && send_enable === 1'b1) begin
         strobes++;
         total++;
         assert (prev_en !== 1'b1)
            else begin bad++; $error("FAIL back_to_back got=%b want=0", prev_en); end
         total++;
         assert (q.size() != 0)
            else begin bad++; $error("FAIL unexpected_strobe got=%h want=none", send_data); end
         if (q.size() != 0) begin
            mon_exp = q.pop_front();
            total++;
            assert (send_data === mon_exp)
               else begin bad++; $error("FAIL strobe_data got=%h want=%h", send_data, mon_exp); end
         end
      end
      prev_en = send_enable;
   end

   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [7:0] b;
      b = d;
      @(posedge clk); #1 rs_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rs_rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      #1 rs_rx = stop;
      repeat (CPB) @(posedge clk);
      #1 rs_rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic push_fib(input int n);
      logic [31:0] a, b, t;
      a = 32'd1;
      b = 32'd2;
      for (int i = 0; i < n; i++) begin
         q.push_back(a);
         t = a + b;
         a = b;
         b = t;
      end
      q.push_back(32'd0);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (30) @(posedge clk);
      total++;
      assert (q.size() == 0)
         else begin bad++; $error("FAIL %s_drain got=%0d left want=0", tag, q.size()); end
      q.delete();
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      total++;
      assert (send_enable === 1'b0)
         else begin bad++; $error("FAIL %s_en got=%b want=0", tag, send_enable); end
      total++;
      assert (send_data === 32'd0)
         else begin bad++; $error("FAIL %s_data got=%h want=0", tag, send_data); end
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      total++;
      assert (got == want)
         else begin bad++; $error("FAIL %s_count got=%0d want=%0d", tag, got, want); end
   endtask

   initial begin
      int s0;
      int n;
      xreset = 1'b0;
      rs_rx  = 1'b1;

      // 1: reset and idle line
      repeat (3) check_idle("in_reset");
      @(posedge clk); #1 xreset = 1'b1;
      for (int i = 0; i < 20; i++) check_idle("idle");

      // 2: N = 10
      s0 = strobes;
      push_fib(10);
      send_frame(8'h0A, 1'b1);
      wait_drain("n10", 200);
      check_count("n10", strobes - s0, 11);
      check_idle("after_n10");

      // 3: N = 0 gives only the terminator
      s0 = strobes;
      push_fib(0);
      send_frame(8'h00, 1'b1);
      wait_drain("n0", 100);
      check_count("n0", strobes - s0, 1);

      // 4: framing error discarded, then a valid N = 1
      s0 = strobes;
      send_frame(8'h03, 1'b0);
      repeat (40) @(posedge clk);
      check_count("ferr", strobes - s0, 0);
      s0 = strobes;
      push_fib(1);
      send_frame(8'h01, 1'b1);
      wait_drain("n1", 100);
      check_count("n1", strobes - s0, 2);

      // 5: one-cycle start glitch
      s0 = strobes;
      @(posedge clk); #1 rs_rx = 1'b0;
      @(posedge clk); #1 rs_rx = 1'b1;
      repeat (100) @(posedge clk);
      check_count("glitch", strobes - s0, 0);

      // 6: reset in the middle of a stream, then N = 2
      s0 = strobes;
      push_fib(10);
      send_frame(8'h0A, 1'b1);
      n = 0;
      while (strobes - s0 < 4 && n < 300) begin
         @(posedge clk);
         n++;
      end
      check_count("pre_reset", (strobes - s0 >= 4) ? 1 : 0, 1);
      @(posedge clk); #2 xreset = 1'b0;
      #1;
      total++;
      assert (send_enable === 1'b0 && send_data === 32'd0)
         else begin bad++; $error("FAIL mid_reset got=%b/%h want=0/0", send_enable, send_data); end
      q.delete();
      repeat (3) check_idle("held_reset");
      @(posedge clk); #1 xreset = 1'b1;
      s0 = strobes;
      repeat (60) @(posedge clk);
      check_count("post_reset", strobes - s0, 0);
      check_idle("post_reset");
      s0 = strobes;
      push_fib(2);
      send_frame(8'h02, 1'b1);
      wait_drain("n2", 100);
      check_count("n2", strobes - s0, 3);

      // 7: N = 255 runs past 2^32 and must wrap
      s0 = strobes;
      push_fib(255);
      send_frame(8'hFF, 1'b1);
      wait_drain("n255", 2000);
      check_count("n255", strobes - s0, 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
